if_stage: RTL

//  Instruction Fetch stage: owns the PC, fetches from instruction memory over a
//  req/gnt/rvalid handshake, and drives the IF/ID pipeline register into the decode stage.

---
 rtl/sys_defs_pkg.sv | 25 ++
 rtl/if_hold_buf.sv | 41 ++++
 rtl/if_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sys_defs_pkg.sv
// Shared fetch-stage definitions: FSM encoding, IF/ID payload and default constants.
package sys_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC_DEF   = 32'd4;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] npc;
  } ifid_t;

  // Fetch addresses are always word aligned, including redirect targets.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {IR,PC,NPC} buffer that parks a fetched word while decode is stalled.
import sys_defs::*;

module if_hold_buf (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t dout,
  output logic  full
);

  ifid_t buf_q, buf_d;
  logic  full_q, full_d;

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      buf_d  = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign dout = buf_q;
  assign full = full_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, squash on redirect, IF/ID register.
import sys_defs::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_hazard_flag,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         squash_q, squash_d;
  ifid_t        ifid_q, ifid_d;
  logic         valid_q, valid_d;

  logic  buf_load, buf_clr, buf_full;
  ifid_t buf_din, buf_dout;
  logic  new_inst, drain;

  assign buf_din = '{ir: imem_rdata, pc: req_pc_q, npc: req_pc_q + PC_INC};

  if_hold_buf u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clr),
    .din   (buf_din),
    .dout  (buf_dout),
    .full  (buf_full)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    squash_d = squash_q;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    new_inst = 1'b0;
    drain    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_INC;
          state_d  = WAIT;
          // A request accepted in the redirect cycle is already on the wrong path.
          if (ex_take_branch) squash_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d  = FETCH;
          squash_d = 1'b0;
          if (!squash_q && !ex_take_branch) begin
            if (!id_hazard_flag) begin
              new_inst = 1'b1;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end else if (ex_take_branch) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (ex_take_branch) begin
          buf_clr = 1'b1;
          state_d = FETCH;
        end else if (!id_hazard_flag) begin
          drain   = buf_full;
          buf_clr = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ex_take_branch) pc_d = word_align(ex_target_pc);
  end

  // IF/ID: redirect bubble > hazard hold > new load > bubble.
  always_comb begin
    ifid_d  = ifid_q;
    valid_d = valid_q;
    if (ex_take_branch) begin
      ifid_d.ir = NOP_INST;
      valid_d   = 1'b0;
    end else if (!id_hazard_flag) begin
      if (new_inst) begin
        ifid_d  = buf_din;
        valid_d = 1'b1;
      end else if (drain) begin
        ifid_d  = buf_dout;
        valid_d = 1'b1;
      end else begin
        ifid_d.ir = NOP_INST;
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      squash_q <= 1'b0;
      ifid_q   <= '{ir: NOP_INST, pc: 32'h0, npc: 32'h0};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      squash_q <= squash_d;
      ifid_q   <= ifid_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req         = (state_q == FETCH);
  assign imem_addr        = pc_q;
  assign if_id_IR         = ifid_q.ir;
  assign if_id_PC         = ifid_q.pc;
  assign if_id_NPC        = ifid_q.npc;
  assign if_id_valid_inst = valid_q;

endmodule
